alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
- Shares the single combinational 8-bit ALU (top: opA, opB, opS -> Result) between two requesters.
- Round-robin arbitration; captures the granted request's operands and drives them onto the ALU for one cycle.
- Registers the ALU result and returns it with a requester ID over a valid/ready response channel.
- Keeps one accumulator per requester, so a request can chain on its own previous result.

Parameters:
- W, 8, data width of operands, result and accumulators (ALU is 8-bit; other values unsupported).
- OP_MAX, 8, highest legal opcode; opcodes above it are illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  W  operand A.
- req0_b  in  W  operand B.
- req0_op  in  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 INVERT, 7 SHL, 8 SHR.
- req0_acc  in  1  use requester 0 accumulator in place of req0_a.
- req1_valid / req1_ready / req1_a / req1_b / req1_op / req1_acc: as requester 0, for requester 1.
- alu_opA  out  W  to ALU opA.
- alu_opB  out  W  to ALU opB.
- alu_opS  out  4  to ALU opS.
- alu_result  in  W  from ALU Result (combinational).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  W  result.
- rsp_id  out  1  requester that issued it.
- rsp_err  out  1  illegal opcode flag.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state IDLE, priority pointer = 0, all operand/op registers 0, acc0 = acc1 = 0.
- Outputs in reset: rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, req*_ready 0, alu_opS 0.
- reqN_ready is combinational and asserted only in IDLE, to the granted requester only.
- Grant rule: if only one reqN_valid is high, grant it. If both are high, grant the requester named by the priority pointer.
- After any grant, the pointer is set to the non-granted requester.
- Accept (IDLE, valid & ready): register the operands, op, acc flag and ID, then go to EXEC.
  - Operand A = accN if reqN_acc = 1, else reqN_a; accN is sampled at accept.
- EXEC (exactly 1 cycle):
  - alu_opA and alu_opB carry the registered operands.
  - alu_opS carries the registered op if it is <= OP_MAX, else 0.
  - At the clock edge: rsp_data <= alu_result (or 0 if the op is illegal), rsp_err <= illegal, rsp_id <= ID, rsp_valid <= 1; go to RESP.
- RESP: rsp_valid, rsp_data, rsp_id and rsp_err are held stable until rsp_ready = 1.
  - On handshake: rsp_valid <= 0; acc[rsp_id] <= rsp_data unless rsp_err is set; go to IDLE.
- Outside EXEC: alu_opS = 0 (NOP); alu_opA/alu_opB hold their last registered values.
- Latency: accept at edge E0, rsp_valid high after E1. Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with rsp_ready = 1).
- Arithmetic: ALU is mod 2^8, no carry/borrow out. SUB 0x00 - 0x01 = 0xFF; ADD 0xFF + 0x01 = 0x00; rsp_err = 0 in both cases.
- Requests are never dropped. A non-granted valid must be held by its requester and is granted in a later IDLE cycle.
- Inputs changing while not ready are ignored.
- Backpressure: with rsp_ready held low, the block stays in RESP indefinitely and no new request is accepted.
- Reset mid-operation (any state): immediate return to reset values. An in-flight request is lost and the accumulators clear.

Test Plan:
- Single request: req0 valid, a=0x12, b=0x34, op=1, rsp_ready=1 -> accepted in IDLE; alu_opS=1 during EXEC; rsp_valid next cycle with rsp_data=0x46, rsp_id=0, rsp_err=0; acc0=0x46 after handshake.
- Simultaneous requests after reset:
  - req0 (0x0F AND 0x3C) and req1 (0xF0 OR 0x0F) both held valid.
  - Grant order req0 then req1 -> responses 0x0C/id0 then 0xFF/id1.
  - Next double request grants req0 first again.
- Accumulator chain: req1 ADD a=0x05 b=0x03 -> 0x08; then req1 acc=1 SHL -> alu_opA=0x08, rsp_data=0x10; then acc=1 SUB b=0x11 -> 0xFF.
- Backpressure: rsp_ready low for 5 cycles with req1 valid pending -> rsp_valid/rsp_data/rsp_id stable, req1_ready stays 0; rsp_ready high -> handshake, then req1 accepted in IDLE.
- Illegal op: req0 op=0xB -> alu_opS=0 in EXEC, rsp_data=0x00, rsp_err=1, acc0 unchanged.
- Reset mid-op: assert rst_n=0 asynchronously while in RESP with acc0=0x46 -> rsp_valid drops without waiting for a clock edge; acc0=0; state IDLE after release.

Source files
------------

// File: rtl/alu_req_scheduler_if.sv
// Request/response bundle between two ALU requesters, a result consumer and the scheduler.
// master = requester/consumer side, slave = scheduler side.
interface alu_req_scheduler_if #(
  parameter int W = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [3:0]   req0_op;
  logic         req0_acc;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [3:0]   req1_op;
  logic         req1_acc;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id;
  logic         rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_acc,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_acc,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_acc,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_acc,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin sharing of one combinational 8-bit ALU between two requesters,
// with a registered valid/ready response and a per-requester accumulator.
module alu_req_scheduler #(
  parameter int W      = 8,
  parameter int OP_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_req_scheduler_if.slave bus,
  output logic [W-1:0]       alu_opA,
  output logic [W-1:0]       alu_opB,
  output logic [3:0]         alu_opS,
  input  logic [W-1:0]       alu_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_MAX_L = 4'(OP_MAX);

  state_t       state_reg;
  state_t       state_next;

  logic [1:0]   req_valid;
  logic [1:0]   req_acc;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a   [2];
  logic [W-1:0] req_b   [2];
  logic [3:0]   req_op  [2];
  logic [W-1:0] acc_cur [2];

  logic         ptr_reg;
  logic         grant;
  logic         accept;
  logic         rsp_done;
  logic         illegal;

  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [3:0]   op_reg;
  logic         id_reg;

  logic         rsp_valid_reg;
  logic [W-1:0] rsp_data_reg;
  logic         rsp_id_reg;
  logic         rsp_err_reg;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_acc   = {bus.req1_acc, bus.req0_acc};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;
  assign req_op[0] = bus.req0_op;
  assign req_op[1] = bus.req1_op;

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    grant = ptr_reg;
    if (req_valid == 2'b01) begin
      grant = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  assign accept   = (state_reg == IDLE) && (|req_valid);
  assign rsp_done = (state_reg == RESP) && bus.rsp_ready;
  assign illegal  = op_reg > OP_MAX_L;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [W-1:0] acc_reg;

    // Ready is gated by rst_n so it is low for the whole reset window.
    assign req_ready[gi] = rst_n && accept && (grant == 1'(gi));
    assign acc_cur[gi]   = acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg <= '0;
      end else if (rsp_done && !rsp_err_reg && (rsp_id_reg == 1'(gi))) begin
        acc_reg <= rsp_data_reg;
      end
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    alu_opS    = 4'd0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
        if (!illegal) begin
          alu_opS = op_reg;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= 4'd0;
      id_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        ptr_reg <= ~grant;
        a_reg   <= req_acc[grant] ? acc_cur[grant] : req_a[grant];
        b_reg   <= req_b[grant];
        op_reg  <= req_op[grant];
        id_reg  <= grant;
      end
      if (state_reg == EXEC) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= illegal ? '0 : alu_result;
        rsp_id_reg    <= id_reg;
        rsp_err_reg   <= illegal;
      end
      if (rsp_done) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_opA       = a_reg;
  assign alu_opB       = b_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model.
module tb_alu_req_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] alu_opA;
  logic [W-1:0] alu_opB;
  logic [3:0]   alu_opS;
  logic [W-1:0] alu_result;

  always #5 clk = ~clk;

  alu_req_scheduler_if #(.W(W)) bus_if ();

  alu_req_scheduler #(.W(W), .OP_MAX(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_opS    (alu_opS),
    .alu_result (alu_result)
  );

  // External combinational ALU the scheduler drives.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      4'd7:    return a << 1;
      4'd8:    return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opS, alu_opA, alu_opB);

  // Expected result from plain integer arithmetic modulo 256.
  function automatic logic [7:0] ref_result(input int op, input int a, input int b);
    int r;
    case (op)
      1:       r = a + b;
      2:       r = a - b + 256;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      6:       r = 255 - a;
      7:       r = a * 2;
      8:       r = a / 2;
      default: r = 0;
    endcase
    return 8'(r % 256);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h expected=%02h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding transaction, accumulators, tie pointer.
  bit         pend [2];
  logic [7:0] m_acc [2];
  bit         m_ptr;
  bit         m_exec;
  bit         m_resp;
  logic [7:0] e_a;
  logic [7:0] e_b;
  logic [3:0] e_op;
  bit         e_id;
  logic [7:0] e_data;
  bit         e_err;
  bit         rand_en;
  int         n_rsp = 0;

  task automatic drive_req(input int n, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic acc);
    if (n == 0) begin
      bus_if.req0_valid = v; bus_if.req0_a = a; bus_if.req0_b = b;
      bus_if.req0_op = op; bus_if.req0_acc = acc;
    end else begin
      bus_if.req1_valid = v; bus_if.req1_a = a; bus_if.req1_b = b;
      bus_if.req1_op = op; bus_if.req1_acc = acc;
    end
  endtask

  task automatic post(input int n, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic acc);
    drive_req(n, 1'b1, a, b, op, acc);
    pend[n] = 1'b1;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(9, 15));
    return 4'($urandom_range(0, 8));
  endfunction

  function automatic bit busy();
    return m_exec || m_resp || pend[0] || pend[1];
  endfunction

  task automatic evaluate();
    logic [1:0] v;
    logic [1:0] rdy;
    logic [1:0] exp_rdy;
    bit         g;
    logic [7:0] ra, rb;
    logic [3:0] rop;
    logic       racc;
    v   = {bus_if.req1_valid, bus_if.req0_valid};
    rdy = {bus_if.req1_ready, bus_if.req0_ready};
    if (m_exec) begin
      chk("exec_opA", alu_opA, e_a);
      chk("exec_opB", alu_opB, e_b);
      chk("exec_opS", 8'(alu_opS), e_err ? 8'h00 : 8'(e_op));
      chk("exec_ready", 8'(rdy), 8'h00);
      chk("exec_rsp_valid", 8'(bus_if.rsp_valid), 8'h00);
      m_exec = 1'b0;
      m_resp = 1'b1;
    end else if (m_resp) begin
      chk("rsp_valid", 8'(bus_if.rsp_valid), 8'h01);
      chk("rsp_data", bus_if.rsp_data, e_data);
      chk("rsp_id", 8'(bus_if.rsp_id), 8'(e_id));
      chk("rsp_err", 8'(bus_if.rsp_err), 8'(e_err));
      chk("resp_ready", 8'(rdy), 8'h00);
      chk("resp_opS", 8'(alu_opS), 8'h00);
      if (bus_if.rsp_ready) begin
        if (!e_err) m_acc[e_id] = e_data;
        m_resp = 1'b0;
        n_rsp++;
        $display("rsp %0d: id=%0d op=%0h a=%02h b=%02h data=%02h err=%0d",
                 n_rsp, e_id, e_op, e_a, e_b, e_data, e_err);
      end
    end else begin
      chk("idle_rsp_valid", 8'(bus_if.rsp_valid), 8'h00);
      chk("idle_opS", 8'(alu_opS), 8'h00);
      g       = (v == 2'b10) ? 1'b1 : (v == 2'b01) ? 1'b0 : m_ptr;
      exp_rdy = (v == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
      chk("idle_ready", 8'(rdy), 8'(exp_rdy));
      if (v != 2'b00) begin
        if (g) begin
          ra = bus_if.req1_a; rb = bus_if.req1_b; rop = bus_if.req1_op; racc = bus_if.req1_acc;
        end else begin
          ra = bus_if.req0_a; rb = bus_if.req0_b; rop = bus_if.req0_op; racc = bus_if.req0_acc;
        end
        e_a    = racc ? m_acc[g] : ra;
        e_b    = rb;
        e_op   = rop;
        e_id   = g;
        e_err  = (int'(rop) > 8);
        e_data = e_err ? 8'h00 : ref_result(int'(rop), int'(e_a), int'(e_b));
        m_ptr  = ~g;
        pend[g] = 1'b0;
        m_exec = 1'b1;
      end
    end
  endtask

  // Entered and left at a falling edge.
  task automatic step();
    for (int n = 0; n < 2; n++) begin
      if (!pend[n]) begin
        if (rand_en && $urandom_range(0, 2) == 0)
          post(n, 8'($urandom), 8'($urandom), rand_op(), 1'($urandom_range(0, 1)));
        else
          drive_req(n, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
      end
    end
    if (rand_en) bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
    #1;
    evaluate();
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while (busy() && k < max) begin
      step();
      k++;
    end
    chk("drain_done", 8'(busy()), 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_req(0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    drive_req(1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_acc[0] = 8'h00; m_acc[1] = 8'h00;
    m_ptr = 1'b0; m_exec = 1'b0; m_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rand_en = 1'b0;
    bus_if.rsp_ready = 1'b1;
    drive_req(0, 1'b1, 8'h12, 8'h34, 4'h1, 1'b0);
    drive_req(1, 1'b1, 8'h56, 8'h78, 4'h2, 1'b0);
    #3;
    chk("rst_ready", 8'({bus_if.req1_ready, bus_if.req0_ready}), 8'h00);
    chk("rst_rsp_valid", 8'(bus_if.rsp_valid), 8'h00);
    chk("rst_rsp_data", bus_if.rsp_data, 8'h00);
    chk("rst_rsp_id", 8'(bus_if.rsp_id), 8'h00);
    chk("rst_rsp_err", 8'(bus_if.rsp_err), 8'h00);
    chk("rst_opS", 8'(alu_opS), 8'h00);
    do_reset();

    // Single request on requester 0.
    post(0, 8'h12, 8'h34, 4'h1, 1'b0);
    drain(10);

    // Simultaneous requests after reset, twice.
    do_reset();
    post(0, 8'h0F, 8'h3C, 4'h3, 1'b0);
    post(1, 8'hF0, 8'h0F, 4'h4, 1'b0);
    drain(20);
    post(0, 8'h0F, 8'h3C, 4'h3, 1'b0);
    post(1, 8'hF0, 8'h0F, 4'h4, 1'b0);
    drain(20);

    // Accumulator chain on requester 1 and wraparound corners.
    post(1, 8'h05, 8'h03, 4'h1, 1'b0);
    drain(10);
    post(1, 8'hAA, 8'h00, 4'h7, 1'b1);
    drain(10);
    post(1, 8'hAA, 8'h11, 4'h2, 1'b1);
    drain(10);
    post(0, 8'hFF, 8'h01, 4'h1, 1'b0);
    drain(10);
    post(0, 8'h00, 8'h01, 4'h2, 1'b0);
    drain(10);

    // Backpressure with requester 1 waiting.
    bus_if.rsp_ready = 1'b0;
    post(0, 8'h21, 8'h43, 4'h5, 1'b0);
    repeat (3) step();
    post(1, 8'h11, 8'h22, 4'h1, 1'b0);
    repeat (5) step();
    bus_if.rsp_ready = 1'b1;
    drain(20);

    // Illegal opcode leaves the accumulator alone.
    post(0, 8'h77, 8'h66, 4'hB, 1'b0);
    drain(10);
    post(0, 8'h00, 8'h01, 4'h1, 1'b1);
    drain(10);

    // Random traffic.
    rand_en = 1'b1;
    repeat (400) step();
    rand_en = 1'b0;
    bus_if.rsp_ready = 1'b1;
    drain(50);

    // Asynchronous reset while a response is held.
    do_reset();
    post(0, 8'h12, 8'h34, 4'h1, 1'b0);
    drain(10);
    bus_if.rsp_ready = 1'b0;
    post(0, 8'h00, 8'h01, 4'h1, 1'b1);
    repeat (3) step();
    #1;
    chk("pre_rst_rsp_valid", 8'(bus_if.rsp_valid), 8'h01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 8'(bus_if.rsp_valid), 8'h00);
    chk("async_rst_rsp_data", bus_if.rsp_data, 8'h00);
    do_reset();
    bus_if.rsp_ready = 1'b1;
    post(0, 8'h99, 8'h00, 4'h1, 1'b1);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
